// File: rtl/ps2_pkg.sv
// -----------------------------------------------------------------------------
// ps2_pkg
// Shared definitions for the PS/2 host transmitter:
//   - ps2_state_t   : transmitter FSM state encoding
//   - CMD_*         : common device command bytes
//   - FRAME_EDGES   : device clock falling edges in one host-to-device frame
//   - STOP_EDGE     : edge on which the stop bit is presented
//   - us_to_cycles(): microseconds to system clock cycles
// -----------------------------------------------------------------------------
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_REQUEST,
        ST_SHIFT,
        ST_ACK,
        ST_WAIT_IDLE,
        ST_DONE
    } ps2_state_t;

    localparam logic [7:0] CMD_RESET         = 8'hFF;
    localparam logic [7:0] CMD_ENABLE_REPORT = 8'hF4;
    localparam logic [7:0] CMD_SET_DEFAULTS  = 8'hF6;

    // 9 edges shift data+parity, the 10th presents stop, the 11th samples ACK.
    localparam logic [3:0] FRAME_EDGES = 4'd11;
    localparam logic [3:0] STOP_EDGE   = 4'd10;

    // 64-bit intermediate so that large CLK_HZ * US products do not overflow.
    function automatic int unsigned us_to_cycles(input int unsigned us,
                                                 input int unsigned clk_hz);
        return 32'(64'(us) * 64'(clk_hz) / 64'd1_000_000);
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// -----------------------------------------------------------------------------
// ps2_sync_edge
// Two-flop synchronizer for an asynchronous PS/2 line plus a falling-edge flag.
// Ports:
//   clk    in  : system clock
//   rst    in  : asynchronous active-high reset (flops preset to line idle = 1)
//   i_line in  : raw line level, asynchronous to clk
//   o_level out: synchronized line level
//   o_fall out : one-cycle pulse, one cycle after o_level goes 1->0
// -----------------------------------------------------------------------------
module ps2_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic i_line,
    output logic o_level,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_sync_d;
    logic r_fall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta   <= 1'b1;
            r_sync   <= 1'b1;
            r_sync_d <= 1'b1;
            r_fall   <= 1'b0;
        end else begin
            r_meta   <= i_line;
            r_sync   <= r_meta;
            r_sync_d <= r_sync;
            r_fall   <= r_sync_d & ~r_sync;
        end
    end

    assign o_level = r_sync;
    assign o_fall  = r_fall;

endmodule

// File: rtl/ps2_host_tx.sv
// -----------------------------------------------------------------------------
// ps2_host_tx
// PS/2 host-to-device command transmitter. Inhibits the bus, issues a request
// to send, shifts out data+odd parity+stop on device clock falling edges,
// samples the device ACK and reports completion or error.
// Ports:
//   clk, rst                 : system clock, asynchronous active-high reset
//   tx_valid, tx_data[7:0]   : command request / byte
//   tx_ready                 : high in IDLE; handshake accepts tx_data
//   ps2_clk_in, ps2_data_in  : raw bus levels (asynchronous)
//   ps2_clk_drive_low        : open-drain enable, pulls PS/2 clock low
//   ps2_data_drive_low       : open-drain enable, pulls PS/2 data low
//   tx_done, tx_ack_ok       : one-cycle completion pulse, ACK status with it
//   tx_error                 : one-cycle pulse on NACK or timeout
//   busy                     : high whenever not IDLE
// -----------------------------------------------------------------------------
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned CLK_HZ           = 100_000_000,
    parameter int unsigned INHIBIT_US       = 100,
    parameter int unsigned START_TIMEOUT_US = 15_000,
    parameter int unsigned FRAME_TIMEOUT_US = 2_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_drive_low,
    output logic       ps2_data_drive_low,
    output logic       tx_done,
    output logic       tx_ack_ok,
    output logic       tx_error,
    output logic       busy
);

    localparam int unsigned INHIBIT_CYC = us_to_cycles(INHIBIT_US, CLK_HZ);
    localparam int unsigned START_CYC   = us_to_cycles(START_TIMEOUT_US, CLK_HZ);
    localparam int unsigned FRAME_CYC   = us_to_cycles(FRAME_TIMEOUT_US, CLK_HZ);
    localparam int unsigned TMO_MAX     = (START_CYC > FRAME_CYC) ? START_CYC : FRAME_CYC;
    // The inhibit interval shares the timer, so it must fit as well.
    localparam int unsigned TIMER_MAX   = (TMO_MAX > INHIBIT_CYC) ? TMO_MAX : INHIBIT_CYC;
    localparam int unsigned TMO_W       = $clog2(TIMER_MAX + 1);

    // Synchronized bus
    logic w_clk_level;
    logic w_clk_fall;
    logic r_data_meta;
    logic r_data_sync;

    ps2_sync_edge u_clk_sync (
        .clk     (clk),
        .rst     (rst),
        .i_line  (ps2_clk_in),
        .o_level (w_clk_level),
        .o_fall  (w_clk_fall)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data_meta <= 1'b1;
            r_data_sync <= 1'b1;
        end else begin
            r_data_meta <= ps2_data_in;
            r_data_sync <= r_data_meta;
        end
    end

    // FSM state and datapath
    ps2_state_t       r_state,    w_state_next;
    logic [TMO_W-1:0] r_timer,    w_timer_next;
    logic [3:0]       r_edge_cnt, w_edge_cnt_next;
    logic             r_data_low, w_data_low_next;
    logic             r_ack_ok,   w_ack_ok_next;
    logic [7:0]       r_byte,     w_byte_next;
    logic             r_parity,   w_parity_next;
    logic             r_tmo_err,  w_tmo_err_next;

    logic [8:0] w_frame_bits;
    logic [3:0] w_edge_inc;

    assign w_frame_bits = {r_parity, r_byte};
    assign w_edge_inc   = r_edge_cnt + 4'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_timer    <= '0;
            r_edge_cnt <= '0;
            r_data_low <= 1'b0;
            r_ack_ok   <= 1'b0;
            r_byte     <= '0;
            r_parity   <= 1'b0;
            r_tmo_err  <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_timer    <= w_timer_next;
            r_edge_cnt <= w_edge_cnt_next;
            r_data_low <= w_data_low_next;
            r_ack_ok   <= w_ack_ok_next;
            r_byte     <= w_byte_next;
            r_parity   <= w_parity_next;
            r_tmo_err  <= w_tmo_err_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_timer_next    = r_timer;
        w_edge_cnt_next = r_edge_cnt;
        w_data_low_next = r_data_low;
        w_ack_ok_next   = r_ack_ok;
        w_byte_next     = r_byte;
        w_parity_next   = r_parity;
        w_tmo_err_next  = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                if (tx_valid) begin
                    w_byte_next     = tx_data;
                    w_parity_next   = ~^tx_data;
                    w_timer_next    = TMO_W'(INHIBIT_CYC - 1);
                    w_edge_cnt_next = '0;
                    w_ack_ok_next   = 1'b0;
                    w_state_next    = ST_INHIBIT;
                end
            end

            ST_INHIBIT: begin
                if (r_timer == '0) begin
                    // Start bit goes out together with the extra clock-low cycle.
                    w_data_low_next = 1'b1;
                    w_state_next    = ST_REQUEST;
                end else begin
                    w_timer_next = r_timer - 1'b1;
                end
            end

            ST_REQUEST: begin
                w_timer_next    = TMO_W'(START_CYC);
                w_edge_cnt_next = '0;
                w_state_next    = ST_SHIFT;
            end

            ST_SHIFT: begin
                if (w_clk_fall) begin
                    w_edge_cnt_next = w_edge_inc;
                    // First device edge switches from start to frame timeout.
                    w_timer_next = (r_edge_cnt == '0) ? TMO_W'(FRAME_CYC) : r_timer - 1'b1;
                    if (w_edge_inc == STOP_EDGE) begin
                        w_data_low_next = 1'b0;
                        w_state_next    = ST_ACK;
                    end else begin
                        w_data_low_next = ~w_frame_bits[r_edge_cnt];
                    end
                end else if (r_timer == '0) begin
                    w_data_low_next = 1'b0;
                    w_tmo_err_next  = 1'b1;
                    w_edge_cnt_next = '0;
                    w_state_next    = ST_IDLE;
                end else begin
                    w_timer_next = r_timer - 1'b1;
                end
            end

            ST_ACK: begin
                if (w_clk_fall) begin
                    w_edge_cnt_next = w_edge_inc;
                    w_ack_ok_next   = ~r_data_sync;
                    w_state_next    = ST_WAIT_IDLE;
                end else if (r_timer == '0) begin
                    w_data_low_next = 1'b0;
                    w_tmo_err_next  = 1'b1;
                    w_edge_cnt_next = '0;
                    w_state_next    = ST_IDLE;
                end else begin
                    w_timer_next = r_timer - 1'b1;
                end
            end

            ST_WAIT_IDLE: begin
                if (w_clk_level && r_data_sync) begin
                    w_state_next = ST_DONE;
                end
            end

            ST_DONE: begin
                w_edge_cnt_next = '0;
                w_timer_next    = '0;
                w_state_next    = ST_IDLE;
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Outputs decode from async-reset state so reset releases the bus at once.
    assign ps2_clk_drive_low  = (r_state == ST_INHIBIT) || (r_state == ST_REQUEST);
    assign ps2_data_drive_low = r_data_low;
    assign tx_ready           = (r_state == ST_IDLE);
    assign busy               = (r_state != ST_IDLE);
    assign tx_done            = (r_state == ST_DONE);
    assign tx_ack_ok          = (r_state == ST_DONE) && r_ack_ok;
    assign tx_error           = ((r_state == ST_DONE) && !r_ack_ok) || r_tmo_err;

    // FRAME_EDGES documents the frame length; the 11th edge is the ACK state's edge.
    if (FRAME_EDGES != STOP_EDGE + 4'd1) begin : g_frame_len_check
        $error("frame length must be stop edge + 1");
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// -----------------------------------------------------------------------------
// tb_ps2_host_tx
// Randomized bench for ps2_host_tx with a behavioural PS/2 device, a frame
// model computed from byte/parity arithmetic and a result scoreboard.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int CLK_HZ    = 100_000_000;
    localparam int INH_US    = 2;
    localparam int START_US  = 20;
    localparam int FRAME_US  = 20;
    localparam int INH_CYC   = 200;
    localparam int START_CYC = 2000;

    typedef struct packed {
        logic done;
        logic ack;
        logic err;
    } res_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_ready, ps2_clk_drive_low, ps2_data_drive_low;
    logic       tx_done, tx_ack_ok, tx_error, busy;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;
    logic       clk_line, data_line;

    assign clk_line  = ~(ps2_clk_drive_low | dev_clk_low);
    assign data_line = ~(ps2_data_drive_low | dev_data_low);

    ps2_host_tx #(
        .CLK_HZ           (CLK_HZ),
        .INHIBIT_US       (INH_US),
        .START_TIMEOUT_US (START_US),
        .FRAME_TIMEOUT_US (FRAME_US)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .tx_valid           (tx_valid),
        .tx_data            (tx_data),
        .tx_ready           (tx_ready),
        .ps2_clk_in         (clk_line),
        .ps2_data_in        (data_line),
        .ps2_clk_drive_low  (ps2_clk_drive_low),
        .ps2_data_drive_low (ps2_data_drive_low),
        .tx_done            (tx_done),
        .tx_ack_ok          (tx_ack_ok),
        .tx_error           (tx_error),
        .busy               (busy)
    );

    always #5 clk = ~clk;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   last_done_cyc = -1;
    int   last_err_cyc = -1;
    int   aa_accept_cyc = -1;
    logic aa_watch = 1'b0;
    logic prev_pulse = 1'b0;
    res_t exp_q[$];
    res_t mon_r;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint got, input longint exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Frame as the device sees it: 8 data bits LSB first, odd parity, stop=1.
    function automatic logic [9:0] model_frame(input logic [7:0] d);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += d[i];
        return {1'b1, ((ones % 2) == 0) ? 1'b1 : 1'b0, d};
    endfunction

    // Compare process: result pulses against the scoreboard, every cycle.
    always @(negedge clk) begin
        if (!rst) begin
            chk("busy_vs_ready", busy, !tx_ready);
            if (tx_done || tx_error) begin
                chk("pulse_single_cycle", prev_pulse, 0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_pulse", {tx_done, tx_error}, 0);
                end else begin
                    mon_r = exp_q.pop_front();
                    chk("result_done", tx_done, mon_r.done);
                    chk("result_ack_ok", tx_ack_ok, mon_r.ack);
                    chk("result_error", tx_error, mon_r.err);
                end
                if (tx_done)  last_done_cyc = cyc;
                if (tx_error) last_err_cyc  = cyc;
            end else begin
                chk("ack_ok_without_done", tx_ack_ok, 0);
            end
            prev_pulse = tx_done || tx_error;
            if (aa_watch && tx_valid && tx_ready && aa_accept_cyc < 0)
                aa_accept_cyc = cyc;
        end
    end

    task automatic send_cmd(input logic [7:0] d);
        int g = 0;
        @(negedge clk);
        while (!tx_ready && g < 5000) begin
            @(negedge clk);
            g++;
        end
        chk("ready_before_send", tx_ready, 1);
        tx_valid = 1'b1;
        tx_data  = d;
        @(negedge clk);
        tx_valid = 1'b0;
        tx_data  = 8'($urandom);   // must not affect the frame in flight
    endtask

    task automatic measure_request(output int n_inh, output int n_req);
        int g = 0;
        n_inh = 0;
        n_req = 0;
        while (!ps2_clk_drive_low && g < 50) begin
            @(negedge clk);
            g++;
        end
        while (ps2_clk_drive_low && !ps2_data_drive_low && n_inh < 1000) begin
            n_inh++;
            @(negedge clk);
        end
        while (ps2_clk_drive_low && ps2_data_drive_low && n_req < 10) begin
            n_req++;
            @(negedge clk);
        end
    endtask

    // Device clocks 11 edges; samples host data at the end of each low phase.
    task automatic device_frame(input bit nack, input int abort_at,
                                output logic [9:0] bits, output logic start_bit);
        bits = '0;
        repeat ($urandom_range(20, 60)) @(negedge clk);
        start_bit = data_line;
        for (int e = 1; e <= 11; e++) begin
            int half = $urandom_range(30, 50);
            if (e == 11) dev_data_low = !nack;
            dev_clk_low = 1'b1;
            if (e == abort_at) return;
            repeat (half) @(negedge clk);
            if (e <= 10) bits[e-1] = data_line;
            dev_clk_low = 1'b0;
            repeat (half) @(negedge clk);
        end
        dev_data_low = 1'b0;
    endtask

    task automatic wait_result(input string name, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        chk(name, exp_q.size(), 0);
    endtask

    task automatic run_frame(input logic [7:0] d, input bit nack, input string tag,
                             output logic [9:0] bits);
        int   n_inh, n_req;
        logic sb;
        res_t r;
        r.done = 1'b1;
        r.ack  = !nack;
        r.err  = nack;
        exp_q.push_back(r);
        measure_request(n_inh, n_req);
        chk({tag, "_inhibit_cycles"}, n_inh, INH_CYC);
        chk({tag, "_request_cycles"}, n_req, 1);
        device_frame(nack, 0, bits, sb);
        chk({tag, "_start_bit"}, sb, 0);
        chk({tag, "_frame_bits"}, bits, model_frame(d));
        wait_result({tag, "_result_timeout"}, 300);
        @(negedge clk);
        chk({tag, "_lines_released"}, {ps2_clk_drive_low, ps2_data_drive_low}, 0);
        $display("txn %s: data=%02h nack=%0d frame=%03h", tag, d, nack, bits);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] bits;
        logic       sb;
        int         n_inh, n_req, t0, el;
        res_t       r;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_tx_ready", tx_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_drives", {ps2_clk_drive_low, ps2_data_drive_low}, 0);
        chk("rst_pulses", {tx_done, tx_ack_ok, tx_error}, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // 0xF4 with ACK
        send_cmd(CMD_ENABLE_REPORT);
        run_frame(CMD_ENABLE_REPORT, 1'b0, "f4_ack", bits);
        chk("f4_bits_literal", bits, 10'h2F4);

        // 0xFF with NACK
        send_cmd(CMD_RESET);
        run_frame(CMD_RESET, 1'b1, "ff_nack", bits);
        chk("ff_bits_literal", bits, 10'h3FF);

        // Silent device -> start timeout
        send_cmd(8'h55);
        r = '{done: 1'b0, ack: 1'b0, err: 1'b1};
        exp_q.push_back(r);
        measure_request(n_inh, n_req);
        chk("tmo_inhibit_cycles", n_inh, INH_CYC);
        t0 = cyc;
        wait_result("start_timeout_result", START_CYC + 200);
        el = last_err_cyc - t0;
        chk("start_timeout_window", (el >= START_CYC && el <= START_CYC + 6), 1);
        @(negedge clk);
        chk("tmo_lines_released", {ps2_clk_drive_low, ps2_data_drive_low}, 0);
        chk("tmo_ready", tx_ready, 1);
        $display("txn timeout: data=55 error after %0d cycles", el);

        // Reset at the 5th falling edge (bit4 of 0x00 keeps data driven low)
        send_cmd(8'h00);
        measure_request(n_inh, n_req);
        device_frame(1'b0, 5, bits, sb);
        repeat (6) @(negedge clk);
        chk("pre_reset_data_drive", ps2_data_drive_low, 1);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_data_release", ps2_data_drive_low, 0);
        chk("rst_async_clk_release", ps2_clk_drive_low, 0);
        chk("rst_async_ready", tx_ready, 1);
        dev_clk_low  = 1'b0;
        dev_data_low = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (50) @(negedge clk);
        $display("txn reset_mid_frame: data=00 aborted at edge 5");

        send_cmd(CMD_SET_DEFAULTS);
        run_frame(CMD_SET_DEFAULTS, 1'b0, "f6_after_rst", bits);
        chk("f6_bits_literal", bits, 10'h3F6);

        // 0xAA held while a 0xF4 frame runs
        send_cmd(CMD_ENABLE_REPORT);
        tx_valid = 1'b1;
        tx_data  = 8'hAA;
        aa_watch = 1'b1;
        run_frame(CMD_ENABLE_REPORT, 1'b0, "f4_busy", bits);
        chk("f4_busy_bits_literal", bits, 10'h2F4);
        for (int g = 0; g < 20 && aa_accept_cyc < 0; g++) @(posedge clk);
        @(negedge clk);
        tx_valid = 1'b0;
        aa_watch = 1'b0;
        chk("aa_accept_after_done", aa_accept_cyc, last_done_cyc + 1);
        run_frame(8'hAA, 1'b0, "aa_queued", bits);
        chk("aa_bits_literal", bits, 10'h3AA);

        // Randomized commands and ACK responses
        for (int k = 0; k < 5; k++) begin
            logic [7:0] d;
            bit         nk;
            d  = 8'($urandom);
            nk = 1'($urandom_range(0, 1));
            send_cmd(d);
            run_frame(d, nk, "random", bits);
        end

        repeat (20) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 Parameter CLK_HZ, default 100_000_000, system clock frequency in Hz.
REQ-002 Parameter INHIBIT_US, default 100, time the host holds PS/2 clock low before a request.
REQ-003 Parameter START_TIMEOUT_US, default 15_000, maximum wait for the device's first clock edge.
REQ-004 Parameter FRAME_TIMEOUT_US, default 2_000, maximum time from the first device edge to ACK.
REQ-005 Ports: clk in 1, system clock; rst in 1, asynchronous, active-high reset (one clock, no other clock).
REQ-006 Ports: tx_valid in 1, command request; tx_data in 8, command byte; tx_ready out 1, request accepted when high with tx_valid.
REQ-007 Ports: ps2_clk_in in 1 and ps2_data_in in 1, raw line levels (asynchronous to clk).
REQ-008 Ports: ps2_clk_drive_low out 1 and ps2_data_drive_low out 1, open-drain enables; top level drives the line 0 when high and 'z when low.
REQ-009 Ports: tx_done out 1, one-cycle end pulse; tx_ack_ok out 1, valid with tx_done; tx_error out 1, one-cycle error pulse; busy out 1.

Function
REQ-010 Line inputs SHALL pass a 2-FF synchronizer, and a device-clock falling edge SHALL be flagged one cycle after the synchronized level goes 1->0.
REQ-011 The FSM SHALL have the states IDLE, INHIBIT, REQUEST, SHIFT, ACK, WAIT_IDLE, and DONE.
REQ-012 In IDLE, tx_ready=1 and busy=0; a tx_valid&tx_ready handshake SHALL latch tx_data, compute parity = ~^tx_data (odd), and go to INHIBIT the next cycle.
REQ-013 INHIBIT SHALL assert ps2_clk_drive_low for exactly INHIBIT_US*CLK_HZ/1e6 cycles, then go to REQUEST.
REQ-014 REQUEST SHALL assert ps2_data_drive_low (start bit), hold clock low for one further cycle, release clock, load the start timeout, and enter SHIFT.
REQ-015 In SHIFT, on each device falling edge n (n=1..9), the data line SHALL present bit n-1 of {parity, data[7:0]} (LSB first, parity ninth); drive_low = ~bit.
REQ-016 The 10th falling edge SHALL release ps2_data_drive_low (stop bit 1) and enter ACK.
REQ-017 In ACK, on the 11th falling edge, the block SHALL sample synchronized data: 0 sets ack_ok=1, 1 sets ack_ok=0; then it SHALL enter WAIT_IDLE.
REQ-018 WAIT_IDLE SHALL wait until both synchronized lines are high, then go to DONE.
REQ-019 DONE SHALL pulse tx_done for one cycle with tx_ack_ok, assert tx_error if ack_ok=0, and return to IDLE.
REQ-020 If no falling edge arrives within START_TIMEOUT after REQUEST, or the 11th edge does not arrive within FRAME_TIMEOUT of the first edge, both drive_low outputs SHALL be released, tx_error SHALL pulse with tx_done=0, and the FSM SHALL return to IDLE.
REQ-021 The edge counter SHALL be 4 bits, and the timeout counter SHALL be sized $clog2 of the larger timeout in cycles; no wrap is permitted before expiry.
REQ-022 tx_valid while busy SHALL be ignored (tx_ready=0); tx_data changes after acceptance SHALL have no effect.
REQ-023 Falling edges seen in IDLE, INHIBIT, or REQUEST SHALL be ignored.

Reset
REQ-024 rst SHALL immediately force IDLE, both drive_low=0, tx_done=0, tx_ack_ok=0, tx_error=0, busy=0, tx_ready=1, counters=0, and synchronizer FFs=1.
REQ-025 Reset mid-frame SHALL release both lines in the same cycle (asynchronously) and produce no tx_done or tx_error pulse.

Structure
REQ-026 Package ps2_pkg SHALL hold the FSM state typedef, command constants (CMD_RESET 8'hFF, CMD_ENABLE_REPORT 8'hF4, CMD_SET_DEFAULTS 8'hF6), and frame length (11 edges).
REQ-027 One sub-module, ps2_sync_edge, SHALL provide the 2-FF synchronizer and falling-edge flag, instantiated for ps2_clk; ps2_data SHALL be synchronized only.

Verification (INHIBIT_US=2, timeouts scaled down; bench models the device clocking at 10-16.7 kHz equivalent)
REQ-028 Sending 0xF4 with the device ACKing SHALL give clock low for 200 cycles, data bits 0,0,1,0,1,1,1,1, parity 0, stop released, tx_done=1, tx_ack_ok=1, tx_error=0.
REQ-029 Sending 0xFF with the device returning ACK=1 SHALL give parity bit 1, tx_done=1, tx_ack_ok=0, and a one-cycle tx_error.
REQ-030 With a silent device after REQUEST, after START_TIMEOUT the block SHALL release both lines, pulse tx_error, give no tx_done, and return to IDLE with tx_ready=1.
REQ-031 Asserting rst at the 5th falling edge SHALL give drive_low outputs 0 within the same cycle, no pulses, and allow a subsequent 0xF6 send to complete correctly.
REQ-032 tx_valid held with 0xAA during a 0xF4 frame SHALL leave the transmitted bits unchanged, and 0xAA SHALL be accepted only after tx_done.
